// File: rtl/ahb_arbiter_slave_gen.sv
// Slave-side AHB arbiter: picks one requesting master (fixed priority or round-robin)
// and holds the grant for the decoded burst length, handing over with no idle cycle.
package AHB_package;
  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_type;
endpackage

module ahb_arbiter_slave_gen
  import AHB_package::*;
#(
  parameter int MASTER_NUM     = 4,
  parameter int ARB_MODE       = 0,
  parameter int MAX_INCR_BEATS = 16
) (
  input  logic                          hclk,
  input  logic                          hreset_n,
  input  logic [MASTER_NUM-1:0]         hreq,
  input  hburst_type                    hburst,
  input  logic                          hwait,
  output logic [MASTER_NUM-1:0]         hgrant,
  output logic                          hsel,
  output logic [$clog2(MASTER_NUM)-1:0] hmaster,
  output logic [MASTER_NUM-1:0]         hlast
);

  localparam int IW      = $clog2(MASTER_NUM);
  localparam int CNT_MAX = (MAX_INCR_BEATS > 16) ? MAX_INCR_BEATS : 16;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t                state_q, state_d;
  logic [MASTER_NUM-1:0] grant_q, grant_d;
  logic [CW-1:0]         count_q, count_d;
  hburst_type            burst_q, burst_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;

  logic [IW-1:0]         win_idx, owner_idx, rr_idx;
  logic [MASTER_NUM-1:0] win_onehot;
  logic                  any_req, owner_req, accepted, last_beat;
  hburst_type            eff_burst;

  // Iterate from the lowest-priority candidate upward so the highest-priority hit is written last.
  always_comb begin
    win_idx = '0;
    rr_idx  = '0;
    if (ARB_MODE == 0) begin
      for (int i = MASTER_NUM - 1; i >= 0; i--) begin
        if (hreq[i]) win_idx = IW'(i);
      end
    end else begin
      for (int k = MASTER_NUM; k >= 1; k--) begin
        rr_idx = IW'((int'(rr_ptr_q) + k) % MASTER_NUM);
        if (hreq[rr_idx]) win_idx = rr_idx;
      end
    end
  end

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (grant_q[i]) owner_idx = IW'(i);
    end
  end

  assign win_onehot = {{(MASTER_NUM-1){1'b0}}, 1'b1} << win_idx;
  assign any_req    = |hreq;
  assign owner_req  = |(hreq & grant_q);
  assign accepted   = (state_q == OWN) && !hwait;
  assign eff_burst  = (count_q == '0) ? hburst : burst_q;

  always_comb begin
    last_beat = 1'b0;
    case (eff_burst)
      SINGLE:         last_beat = (count_q == CW'(0));
      WRAP4, INCR4:   last_beat = (count_q == CW'(3));
      WRAP8, INCR8:   last_beat = (count_q == CW'(7));
      WRAP16, INCR16: last_beat = (count_q == CW'(15));
      INCR:           last_beat = !owner_req || (count_q == CW'(MAX_INCR_BEATS - 1));
      default:        last_beat = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    count_d  = count_q;
    burst_d  = burst_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d  = win_onehot;
          count_d  = '0;
          rr_ptr_d = win_idx;
          state_d  = OWN;
        end
      end
      OWN: begin
        if (accepted) begin
          if (count_q == '0) burst_d = hburst;
          if (last_beat) begin
            count_d = '0;
            if (any_req) begin
              grant_d  = win_onehot;
              rr_ptr_d = win_idx;
            end else begin
              grant_d = '0;
              state_d = IDLE;
            end
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      count_q  <= '0;
      burst_q  <= SINGLE;
      rr_ptr_q <= IW'(MASTER_NUM - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      count_q  <= count_d;
      burst_q  <= burst_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign hgrant  = grant_q & {MASTER_NUM{~hwait}};
  assign hsel    = |grant_q;
  assign hmaster = owner_idx;
  assign hlast   = grant_q & {MASTER_NUM{accepted & last_beat}};

endmodule

// File: tb/tb_ahb_arbiter_slave_gen.sv
// Scoreboard bench: one fixed-priority instance (INCR cap 4) and one round-robin
// instance share stimulus; each queued expectation names the instance it checks.
module tb_ahb_arbiter_slave_gen;
  import AHB_package::*;

  logic       hclk = 1'b0;
  logic       hreset_n;
  logic [3:0] hreq;
  hburst_type hburst;
  logic       hwait;

  logic [3:0] g_f, l_f, g_r, l_r;
  logic       s_f, s_r;
  logic [1:0] m_f, m_r;

  always #5 hclk = ~hclk;

  ahb_arbiter_slave_gen #(.MASTER_NUM(4), .ARB_MODE(0), .MAX_INCR_BEATS(4)) u_fix (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hburst(hburst), .hwait(hwait),
    .hgrant(g_f), .hsel(s_f), .hmaster(m_f), .hlast(l_f)
  );

  ahb_arbiter_slave_gen #(.MASTER_NUM(4), .ARB_MODE(1), .MAX_INCR_BEATS(16)) u_rr (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hburst(hburst), .hwait(hwait),
    .hgrant(g_r), .hsel(s_r), .hmaster(m_r), .hlast(l_r)
  );

  typedef struct {
    bit         rr;
    logic [3:0] g;
    logic       s;
    logic [1:0] m;
    logic [3:0] l;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   tag_cnt = 0;

  task automatic chk(input string name, input int tag, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, tag, act, exp);
    end
  endtask

  always @(negedge hclk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("hgrant",  cur.tag, cur.rr ? g_r : g_f,                   cur.g);
      chk("hsel",    cur.tag, {3'b0, cur.rr ? s_r : s_f},           {3'b0, cur.s});
      chk("hmaster", cur.tag, {2'b0, cur.rr ? m_r : m_f},           {2'b0, cur.m});
      chk("hlast",   cur.tag, cur.rr ? l_r : l_f,                   cur.l);
      $display("step %0d dut=%s req=%b burst=%0d wait=%b rstn=%b grant=%b sel=%b master=%0d last=%b",
               cur.tag, cur.rr ? "rr" : "fix", hreq, hburst, hwait, hreset_n,
               cur.rr ? g_r : g_f, cur.rr ? s_r : s_f, cur.rr ? m_r : m_f, cur.rr ? l_r : l_f);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic cyc(input bit rr, input logic [3:0] req, input hburst_type b, input logic w,
                     input logic rstn, input logic [3:0] eg, input logic es,
                     input logic [1:0] em, input logic [3:0] el);
    exp_t e;
    hreq     = req;
    hburst   = b;
    hwait    = w;
    hreset_n = rstn;
    e.rr = rr; e.g = eg; e.s = es; e.m = em; e.l = el; e.tag = tag_cnt;
    tag_cnt++;
    exp_q.push_back(e);
    @(posedge hclk);
    #1;
  endtask

  initial begin
    hreset_n = 1'b0;
    hreq     = '0;
    hburst   = SINGLE;
    hwait    = 1'b0;
    @(posedge hclk);
    #1;

    // reset state, requests ignored while held in reset
    cyc(0, 4'b0000, SINGLE, 0, 0, 4'b0000, 0, 2'd0, 4'b0000);
    cyc(1, 4'b1111, SINGLE, 0, 0, 4'b0000, 0, 2'd0, 4'b0000);

    // fixed priority, SINGLE beats
    cyc(0, 4'b1010, SINGLE, 0, 1, 4'b0000, 0, 2'd0, 4'b0000);
    cyc(0, 4'b1000, SINGLE, 0, 1, 4'b0010, 1, 2'd1, 4'b0010);
    cyc(0, 4'b0000, SINGLE, 0, 1, 4'b1000, 1, 2'd3, 4'b1000);
    cyc(0, 4'b0000, SINGLE, 0, 1, 4'b0000, 0, 2'd0, 4'b0000);

    // INCR8 by master 2 with waits on beats 3 and 6
    cyc(0, 4'b0100, INCR8, 0, 1, 4'b0000, 0, 2'd0, 4'b0000);
    cyc(0, 4'b0100, INCR8, 0, 1, 4'b0100, 1, 2'd2, 4'b0000);
    cyc(0, 4'b0100, INCR8, 0, 1, 4'b0100, 1, 2'd2, 4'b0000);
    cyc(0, 4'b0100, INCR8, 1, 1, 4'b0000, 1, 2'd2, 4'b0000);
    for (int i = 0; i < 3; i++)
      cyc(0, 4'b0100, INCR8, 0, 1, 4'b0100, 1, 2'd2, 4'b0000);
    cyc(0, 4'b0100, INCR8, 1, 1, 4'b0000, 1, 2'd2, 4'b0000);
    cyc(0, 4'b0100, INCR8, 0, 1, 4'b0100, 1, 2'd2, 4'b0000);
    cyc(0, 4'b0100, INCR8, 0, 1, 4'b0100, 1, 2'd2, 4'b0000);
    cyc(0, 4'b0000, INCR8, 0, 1, 4'b0100, 1, 2'd2, 4'b0100);
    cyc(0, 4'b0000, INCR8, 0, 1, 4'b0000, 0, 2'd0, 4'b0000);

    // round-robin fairness from a fresh reset
    cyc(1, 4'b0000, SINGLE, 0, 0, 4'b0000, 0, 2'd0, 4'b0000);
    cyc(1, 4'b1111, SINGLE, 0, 1, 4'b0000, 0, 2'd0, 4'b0000);
    cyc(1, 4'b1111, SINGLE, 0, 1, 4'b0001, 1, 2'd0, 4'b0001);
    cyc(1, 4'b1111, SINGLE, 0, 1, 4'b0010, 1, 2'd1, 4'b0010);
    cyc(1, 4'b1111, SINGLE, 0, 1, 4'b0100, 1, 2'd2, 4'b0100);
    cyc(1, 4'b1111, SINGLE, 0, 1, 4'b1000, 1, 2'd3, 4'b1000);
    cyc(1, 4'b0000, SINGLE, 0, 1, 4'b0001, 1, 2'd0, 4'b0001);
    cyc(1, 4'b0000, SINGLE, 0, 1, 4'b0000, 0, 2'd0, 4'b0000);

    // INCR capped at 4 beats, then a rerun ended early by dropping the request
    cyc(0, 4'b0001, INCR, 0, 1, 4'b0000, 0, 2'd0, 4'b0000);
    for (int i = 0; i < 3; i++)
      cyc(0, 4'b0001, INCR, 0, 1, 4'b0001, 1, 2'd0, 4'b0000);
    cyc(0, 4'b0001, INCR, 0, 1, 4'b0001, 1, 2'd0, 4'b0001);
    cyc(0, 4'b0001, INCR, 0, 1, 4'b0001, 1, 2'd0, 4'b0000);
    cyc(0, 4'b0000, INCR, 0, 1, 4'b0001, 1, 2'd0, 4'b0001);
    cyc(0, 4'b0000, INCR, 0, 1, 4'b0000, 0, 2'd0, 4'b0000);

    // WRAP4 runs full length despite dropped request and a changed live hburst
    cyc(0, 4'b0010, WRAP4, 0, 1, 4'b0000, 0, 2'd0, 4'b0000);
    cyc(0, 4'b0010, WRAP4, 0, 1, 4'b0010, 1, 2'd1, 4'b0000);
    cyc(0, 4'b0000, INCR,  0, 1, 4'b0010, 1, 2'd1, 4'b0000);
    cyc(0, 4'b0000, INCR,  0, 1, 4'b0010, 1, 2'd1, 4'b0000);
    cyc(0, 4'b0000, INCR,  0, 1, 4'b0010, 1, 2'd1, 4'b0010);
    cyc(0, 4'b0000, INCR,  0, 1, 4'b0000, 0, 2'd0, 4'b0000);

    // asynchronous reset during beat 2 of an INCR16; master 0 wins first afterwards
    cyc(1, 4'b1111, INCR16, 0, 1, 4'b0000, 0, 2'd0, 4'b0000);
    cyc(1, 4'b1111, INCR16, 0, 1, 4'b0100, 1, 2'd2, 4'b0000);
    cyc(1, 4'b1111, INCR16, 0, 0, 4'b0000, 0, 2'd0, 4'b0000);
    cyc(1, 4'b1111, INCR16, 0, 1, 4'b0000, 0, 2'd0, 4'b0000);
    cyc(1, 4'b0000, INCR,   0, 1, 4'b0001, 1, 2'd0, 4'b0001);
    cyc(1, 4'b0000, INCR,   0, 1, 4'b0000, 0, 2'd0, 4'b0000);

    @(negedge hclk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
